arm_audio_sample_fifo: RTL and testbench
========================================

Name: arm_audio_sample_fifo

Overview:
- ARM-facing PCM playback buffer inside ece453_master_module, between the mezzanine-B ARM926 bus and the AC97 link serializer.
- ARM writes packed stereo samples (L[31:16], R[15:0]) through a memory-mapped register window.
- The AC97 serializer pops one sample per frame through a req/ack handshake.
- A low-watermark interrupt on ARM_IRQ tells the ARM to refill.

Parameters:
- DEPTH_LOG2, 8, log2 of FIFO depth (256 entries of 32 bits).
- WM_RESET, 64, reset value of the watermark register.

Ports:
- SYS_CLK  input  1  24 MHz system clock; the only clock.
- SYS_RST_N  input  1  asynchronous active-low reset.
- arm_cs_b  input  1  chip select from ARM_CS1_B, asynchronous, active low.
- arm_rw  input  1  1 = read, 0 = write; asynchronous.
- arm_addr  input  2  word address, ARM_A[3:2].
- arm_wdata  input  32  ARM write data.
- arm_rdata  output  32  read data, registered.
- arm_rdata_oe  output  1  drive enable for the ARM_D tristate in the parent.
- arm_irq  output  1  interrupt, active high, level.
- smp_req  input  1  one-cycle pulse from the AC97 serializer, once per frame.
- smp_ack  output  1  one-cycle pulse answering smp_req.
- smp_data  output  32  sample presented with smp_ack.

Behaviour:
- Reset (async, SYS_RST_N low): arm_rdata=0, arm_rdata_oe=0, arm_irq=0, smp_ack=0, smp_data=0. Pointers=0, level=0, CTRL=0, WM=WM_RESET, sticky flags=0.
- Bus sync: arm_cs_b and arm_rw each pass through a 2-FF synchronizer.
- Access detect: a falling edge of synchronized cs_b marks an access. arm_addr and arm_wdata are sampled on the following cycle (the async bus holds them for all of CS low). Exactly one access per CS assertion.
- Bus FSM states: IDLE -> SETUP (edge seen) -> ACCESS (write performed or rdata registered) -> HOLD (wait for synced cs_b=1) -> IDLE.
- arm_rdata_oe=1 only in ACCESS/HOLD with synced rw=1. It deasserts the cycle after synced cs_b rises.
- Register map:
  - 0 DATA: write pushes arm_wdata; read returns 0.
  - 1 STATUS: read {underrun[31], overflow[30], full[17], empty[16], level[8:0]}. Write 1 to bit 31/30 clears that sticky flag.
  - 2 CTRL: bit0 enable, bit1 irq_en, bit2 flush. Flush is self-clearing: pointers and level zeroed in one cycle, reads back 0.
  - 3 WM: bits[8:0] low watermark.
- Push: on a DATA write when not full, the entry is written and level+1. When full, the write is dropped and overflow=1.
- Pop: smp_req=1 -> smp_ack=1 exactly one cycle later.
  - If enable=1 and non-empty: smp_data = head entry, level-1.
  - Otherwise smp_data=0 (silence). If enable=1 and empty, underrun=1.
  - smp_data holds its value until the next ack.
- Simultaneous push and pop in one cycle: both occur, level unchanged. When full, the push still succeeds because the pop frees a slot in that same cycle.
- Flush in the same cycle as push/pop: flush wins and both are discarded. smp_ack still fires, with data 0.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Level is DEPTH_LOG2+1 bits; full = (level == 2^DEPTH_LOG2).
- arm_irq = enable & irq_en & (level < WM), registered, so one cycle of latency. It drops once level >= WM.
- Storage: inferred RAM with a synchronous read. The head entry is prefetched so smp_data meets the one-cycle ack.
- smp_req while smp_ack is already pending is ignored; the serializer never requests faster than once per 2 cycles.

Test Plan:
- Reset, then read STATUS: 0x00010000 (empty), arm_irq=0, WM reads 64.
- CTRL=3, write 10 samples 0x00010001..0x000A000A: level=10, arm_irq=1. Write 60 more: level=70 and arm_irq drops 1 cycle after level reaches 64.
- With 3 entries, issue 4 smp_req pulses: acks return 0x00010001, 0x00020002, 0x00030003, then 0x0. STATUS bit 31=1; writing 0x80000000 clears it.
- Fill 256 entries and write one more: level=256, full=1, overflow=1. The next pop returns the first sample written, not the 257th.
- smp_req coincident with the write of entry 257 while full: level stays 256, overflow=0, ack data = oldest entry.
- Write CTRL flush mid-stream, then assert SYS_RST_N=0 during an ARM write in SETUP: level=0 after each, outputs return to reset values immediately, and no spurious push occurs after release.

Source files
------------

// File: rtl/arm_audio_sample_fifo.sv
// ARM-facing PCM playback FIFO. The ARM926 asynchronous bus writes packed
// stereo samples (L[31:16], R[15:0]) through a four-word register window.
// The AC97 serializer pops one sample per frame with a req/ack handshake.
// A low-watermark level interrupt asks the ARM to refill.
//
// Handshake (sample side): smp_req is a one-cycle request. It is accepted
// only when no ack is currently being presented. smp_ack pulses for exactly
// one cycle, on the cycle after the accepted request. smp_data is valid with
// smp_ack and holds its value until the next ack.
module arm_audio_sample_fifo #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WM_RESET   = 64
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST_N,
  input  logic        arm_cs_b,
  input  logic        arm_rw,
  input  logic [1:0]  arm_addr,
  input  logic [31:0] arm_wdata,
  output logic [31:0] arm_rdata,
  output logic        arm_rdata_oe,
  output logic        arm_irq,
  input  logic        smp_req,
  output logic        smp_ack,
  output logic [31:0] smp_data,
  output logic [1:0]  dbg_bus_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} bus_state_t;

  bus_state_t            state;
  logic                  cs_s1, cs_s2, cs_prev, rw_s1, rw_s2;
  logic [1:0]            lat_addr;
  logic [31:0]           lat_wdata;
  logic                  lat_rw;
  logic [31:0]           rd_mux;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         level, wm;
  logic                  enable, irq_en, underrun, overflow;
  logic                  cs_fall, wr_stb, push_req, flush, accept;
  logic                  is_empty, is_full, pop, push;

  assign cs_fall  = cs_prev & ~cs_s2;
  assign wr_stb   = (state == S_ACCESS) & ~lat_rw;
  assign push_req = wr_stb & (lat_addr == 2'd0);
  assign flush    = wr_stb & (lat_addr == 2'd2) & lat_wdata[2];
  assign accept   = smp_req & ~smp_ack;
  assign is_empty = (level == '0);
  assign is_full  = (level == LW'(DEPTH));
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop      = accept & enable & ~is_empty & ~flush;
  assign push     = push_req & ~flush & (~is_full | pop);

  assign arm_rdata_oe  = ((state == S_ACCESS) || (state == S_HOLD)) && rw_s2;
  assign dbg_bus_state = state;

  // Two-flop synchronizers for the asynchronous strobes, plus edge history.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_prev <= 1'b1;
      rw_s1   <= 1'b0;
      rw_s2   <= 1'b0;
    end else begin
      cs_s1   <= arm_cs_b;
      cs_s2   <= cs_s1;
      cs_prev <= cs_s2;
      rw_s1   <= arm_rw;
      rw_s2   <= rw_s1;
    end
  end

  // Register read mux, selected by the latched word address.
  always_comb begin
    rd_mux = '0;
    case (lat_addr)
      2'd1:    rd_mux = {underrun, overflow, 12'd0, is_full, is_empty, 16'(level)};
      2'd2:    rd_mux = {30'd0, irq_en, enable};
      2'd3:    rd_mux = 32'(wm);
      default: rd_mux = '0;
    endcase
  end

  // Bus FSM: one access per chip-select assertion; address/data are latched
  // one cycle after the edge, when the async bus is known to be stable.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state     <= S_IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rw    <= 1'b0;
      arm_rdata <= '0;
    end else begin
      case (state)
        S_IDLE:   if (cs_fall) state <= S_SETUP;
        S_SETUP: begin
          lat_addr  <= arm_addr;
          lat_wdata <= arm_wdata;
          lat_rw    <= rw_s2;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (lat_rw) arm_rdata <= rd_mux;
          state <= S_HOLD;
        end
        S_HOLD:   if (cs_s2) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Control, watermark and sticky status flags; a new event beats a clear.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      wm       <= LW'(WM_RESET);
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_stb && lat_addr == 2'd2) begin
        enable <= lat_wdata[0];
        irq_en <= lat_wdata[1];
      end
      if (wr_stb && lat_addr == 2'd3) wm <= lat_wdata[LW-1:0];
      underrun <= (underrun & ~(wr_stb & (lat_addr == 2'd1) & lat_wdata[31]))
                | (accept & enable & is_empty);
      overflow <= (overflow & ~(wr_stb & (lat_addr == 2'd1) & lat_wdata[30]))
                | (push_req & ~flush & is_full & ~pop);
    end
  end

  // Pointers and fill level; flush discards any push or pop in its cycle.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample storage write port.
  always_ff @(posedge SYS_CLK) begin
    if (push) mem[wr_ptr] <= lat_wdata;
  end

  // Synchronous read of the head entry straight into the ack data register;
  // read-before-write keeps the oldest sample when a full FIFO pushes and pops.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      smp_ack  <= 1'b0;
      smp_data <= '0;
    end else begin
      smp_ack <= accept;
      if (accept) smp_data <= pop ? mem[rd_ptr] : '0;
    end
  end

  // Level interrupt, registered one cycle behind the fill level.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) arm_irq <= 1'b0;
    else            arm_irq <= enable & irq_en & (level < wm);
  end

endmodule

// File: tb/tb_arm_audio_sample_fifo.sv
// Bench for arm_audio_sample_fifo: directed scenarios followed by random
// register/sample traffic, checked against a queue-based model.
module tb_arm_audio_sample_fifo;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST_N = 1'b1;
  logic        arm_cs_b = 1'b1;
  logic        arm_rw = 1'b0;
  logic [1:0]  arm_addr = '0;
  logic [31:0] arm_wdata = '0;
  logic [31:0] arm_rdata;
  logic        arm_rdata_oe;
  logic        arm_irq;
  logic        smp_req = 1'b0;
  logic        smp_ack;
  logic [31:0] smp_data;
  logic [1:0]  dbg_bus_state;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] exp_q[$];
  bit          m_en, m_irqen, m_und, m_ovf;
  int          m_wm;

  // Clock / reset block.
  always #5 SYS_CLK = ~SYS_CLK;

  arm_audio_sample_fifo #(.DEPTH_LOG2(8), .WM_RESET(64)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST_N(SYS_RST_N),
    .arm_cs_b(arm_cs_b), .arm_rw(arm_rw), .arm_addr(arm_addr),
    .arm_wdata(arm_wdata), .arm_rdata(arm_rdata), .arm_rdata_oe(arm_rdata_oe),
    .arm_irq(arm_irq), .smp_req(smp_req), .smp_ack(smp_ack),
    .smp_data(smp_data), .dbg_bus_state(dbg_bus_state)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_irq();
    return m_en && m_irqen && (exp_q.size() < m_wm);
  endfunction

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      2'd1: v = (32'(m_und) << 31) | (32'(m_ovf) << 30)
              | (32'(exp_q.size() == 256) << 17) | (32'(exp_q.size() == 0) << 16)
              | 32'(exp_q.size());
      2'd2: v = {30'd0, m_irqen, m_en};
      2'd3: v = 32'(m_wm);
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_en = 0; m_irqen = 0; m_und = 0; m_ovf = 0; m_wm = 64;
  endtask

  // A sample request as seen by the model: returns the expected ack data.
  task automatic model_pop(input bit flush, output logic [31:0] d);
    d = 32'h0;
    if (m_en && exp_q.size() == 0) m_und = 1;
    else if (m_en && !flush) d = exp_q.pop_front();
  endtask

  // ARM write; optionally a sample request lands on the same cycle as the write.
  task automatic arm_write(input logic [1:0] a, input logic [31:0] d, input bit with_pop);
    logic [31:0] pd;
    bit irq_old, flush;
    @(negedge SYS_CLK);
    arm_addr = a; arm_wdata = d; arm_rw = 1'b0; arm_cs_b = 1'b0;
    repeat (4) @(posedge SYS_CLK);
    if (with_pop) begin
      @(negedge SYS_CLK);
      smp_req = 1'b1;
    end
    irq_old = m_irq();
    flush = (a == 2'd2) && d[2];
    pd = 32'h0;
    if (a == 2'd1) begin
      if (d[31]) m_und = 0;
      if (d[30]) m_ovf = 0;
    end
    if (with_pop) model_pop(flush, pd);
    case (a)
      2'd0: if (exp_q.size() < 256) exp_q.push_back(d); else m_ovf = 1;
      2'd2: begin
        m_en = d[0]; m_irqen = d[1];
        if (d[2]) exp_q.delete();
      end
      2'd3: m_wm = int'(d[8:0]);
      default: ;
    endcase
    @(posedge SYS_CLK); #1;
    if (with_pop) begin
      check("wr_pop_ack", smp_ack, 1);
      check("wr_pop_data", smp_data, pd);
    end
    check("wr_irq_pre", arm_irq, irq_old);
    check("wr_oe", arm_rdata_oe, 0);
    if (with_pop) begin
      @(negedge SYS_CLK);
      smp_req = 1'b0;
    end
    @(posedge SYS_CLK); #1;
    check("wr_irq_post", arm_irq, m_irq());
    if (with_pop) check("wr_ack_one_cycle", smp_ack, 0);
    repeat (2) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    arm_cs_b = 1'b1;
    repeat (6) @(posedge SYS_CLK);
  endtask

  task automatic arm_read(input logic [1:0] a, input logic [31:0] exp);
    @(negedge SYS_CLK);
    arm_addr = a; arm_rw = 1'b1; arm_cs_b = 1'b0;
    repeat (5) @(posedge SYS_CLK); #1;
    check("rd_data", arm_rdata, exp);
    check("rd_oe", arm_rdata_oe, 1);
    @(negedge SYS_CLK);
    arm_cs_b = 1'b1;
    repeat (2) @(posedge SYS_CLK); #1;
    check("rd_oe_hold", arm_rdata_oe, 1);
    @(posedge SYS_CLK); #1;
    check("rd_oe_release", arm_rdata_oe, 0);
    repeat (3) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    arm_rw = 1'b0;
  endtask

  task automatic smp_pop();
    logic [31:0] d;
    bit irq_old;
    @(negedge SYS_CLK);
    smp_req = 1'b1;
    irq_old = m_irq();
    model_pop(1'b0, d);
    @(posedge SYS_CLK); #1;
    check("pop_ack", smp_ack, 1);
    check("pop_data", smp_data, d);
    check("pop_irq_pre", arm_irq, irq_old);
    @(negedge SYS_CLK);
    smp_req = 1'b0;
    @(posedge SYS_CLK); #1;
    check("pop_ack_drop", smp_ack, 0);
    check("pop_data_hold", smp_data, d);
    check("pop_irq_post", arm_irq, m_irq());
    repeat (2) @(posedge SYS_CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, arm_rdata, 0);
    check({tag, "_oe"}, arm_rdata_oe, 0);
    check({tag, "_irq"}, arm_irq, 0);
    check({tag, "_ack"}, smp_ack, 0);
    check({tag, "_sdata"}, smp_data, 0);
  endtask

  initial begin
    logic [31:0] v;
    int r;
    model_reset();
    #2 SYS_RST_N = 1'b0;
    repeat (3) @(posedge SYS_CLK); #1;
    check_reset_outputs("reset");
    @(negedge SYS_CLK);
    SYS_RST_N = 1'b1;
    repeat (3) @(posedge SYS_CLK);

    // Reset register state.
    arm_read(2'd1, 32'h0001_0000);
    arm_read(2'd3, 32'd64);
    arm_read(2'd2, 32'h0);
    check("irq_after_reset", arm_irq, 0);

    // Enable with interrupts, then climb past the watermark.
    arm_write(2'd2, 32'd3, 0);
    for (int i = 1; i <= 10; i++) arm_write(2'd0, i * 32'h0001_0001, 0);
    arm_read(2'd1, m_reg(2'd1));
    check("irq_below_wm", arm_irq, 1);
    for (int i = 11; i <= 70; i++) arm_write(2'd0, i * 32'h0001_0001, 0);
    arm_read(2'd1, m_reg(2'd1));
    check("irq_above_wm", arm_irq, 0);
    arm_read(2'd0, 32'h0);
    arm_read(2'd2, 32'd3);

    // Underrun: three samples, four requests.
    arm_write(2'd2, 32'd7, 0);
    arm_read(2'd2, 32'd3);
    for (int i = 1; i <= 3; i++) arm_write(2'd0, i * 32'h0001_0001, 0);
    for (int i = 0; i < 4; i++) smp_pop();
    arm_read(2'd1, m_reg(2'd1));
    arm_write(2'd1, 32'h8000_0000, 0);
    arm_read(2'd1, m_reg(2'd1));

    // Fill to full, overflow, then push and pop together while full.
    arm_write(2'd2, 32'd7, 0);
    arm_write(2'd1, 32'hC000_0000, 0);
    for (int i = 0; i < 256; i++) arm_write(2'd0, $urandom, 0);
    arm_write(2'd0, $urandom, 0);
    arm_read(2'd1, m_reg(2'd1));
    smp_pop();
    arm_write(2'd0, $urandom, 0);
    arm_write(2'd1, 32'h4000_0000, 0);
    arm_write(2'd0, $urandom, 1);
    arm_read(2'd1, m_reg(2'd1));

    // Flush while a sample request lands in the same cycle.
    arm_write(2'd2, 32'd7, 1);
    arm_read(2'd1, m_reg(2'd1));
    arm_read(2'd2, 32'd3);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: arm_write(2'd0, $urandom, ($urandom_range(0, 3) == 0));
        4, 5:       smp_pop();
        6:          begin v = 32'($urandom_range(0, 3)); arm_read(v[1:0], m_reg(v[1:0])); end
        7:          arm_write(2'd2, 32'($urandom_range(0, 3)) | (($urandom_range(0, 9) == 0) ? 32'd4 : 32'd0), 0);
        8:          arm_write(2'd3, 32'($urandom_range(0, 100)), 0);
        default:    arm_write(2'd1, $urandom & 32'hC000_0000, 0);
      endcase
    end

    // Reset asserted while a DATA write sits in SETUP.
    arm_write(2'd2, 32'd3, 0);
    for (int i = 0; i < 4; i++) arm_write(2'd0, $urandom, 0);
    @(negedge SYS_CLK);
    arm_addr = 2'd0; arm_wdata = 32'hDEAD_BEEF; arm_rw = 1'b0; arm_cs_b = 1'b0;
    repeat (3) @(posedge SYS_CLK); #1;
    SYS_RST_N = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst_setup");
    @(negedge SYS_CLK);
    arm_cs_b = 1'b1;
    repeat (4) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    SYS_RST_N = 1'b1;
    repeat (4) @(posedge SYS_CLK);
    arm_read(2'd1, 32'h0001_0000);
    arm_read(2'd3, 32'd64);
    arm_write(2'd2, 32'd3, 0);
    arm_read(2'd1, m_reg(2'd1));
    smp_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
